// File: rtl/copperv_lsu_pkg.sv
// Shared types and codes for the copperv load/store unit.
// FSM encoding, memory funct codes and write-response codes.
package copperv_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } lsu_state_t;

  localparam logic [1:0] FUNCT_MEM_BYTE = 2'd0;
  localparam logic [1:0] FUNCT_MEM_HALF = 2'd1;
  localparam logic [1:0] FUNCT_MEM_WORD = 2'd2;
  localparam logic [1:0] FUNCT_MEM_DBL  = 2'd3;

  localparam int DATA_WRITE_RESP_OK   = 0;
  localparam int DATA_WRITE_RESP_FAIL = 1;

endpackage

// File: rtl/copperv_lsu_if.sv
// Core request/response plus split read/write data bus.
// master = LSU side, slave = core/memory side.
interface copperv_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RESP_WIDTH = 2
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_funct;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic                    resp_err;
  logic [DATA_WIDTH-1:0]   resp_rdata;

  logic                    dr_addr_valid;
  logic                    dr_addr_ready;
  logic [ADDR_WIDTH-1:0]   dr_addr;
  logic                    dr_data_valid;
  logic                    dr_data_ready;
  logic [DATA_WIDTH-1:0]   dr_data;

  logic                    dw_data_addr_valid;
  logic                    dw_data_addr_ready;
  logic [ADDR_WIDTH-1:0]   dw_addr;
  logic [DATA_WIDTH-1:0]   dw_data;
  logic [DATA_WIDTH/8-1:0] dw_strobe;
  logic                    dw_resp_valid;
  logic                    dw_resp_ready;
  logic [RESP_WIDTH-1:0]   dw_resp;

  modport master (
    input  req_valid, req_we, req_funct,
    input  req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_err, resp_rdata,
    output dr_addr_valid, dr_addr,
    input  dr_addr_ready,
    input  dr_data_valid, dr_data,
    output dr_data_ready,
    output dw_data_addr_valid,
    output dw_addr, dw_data, dw_strobe,
    input  dw_data_addr_ready,
    input  dw_resp_valid, dw_resp,
    output dw_resp_ready
  );

  modport slave (
    output req_valid, req_we, req_funct,
    output req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_err, resp_rdata,
    input  dr_addr_valid, dr_addr,
    output dr_addr_ready,
    output dr_data_valid, dr_data,
    input  dr_data_ready,
    input  dw_data_addr_valid,
    input  dw_addr, dw_data, dw_strobe,
    output dw_data_addr_ready,
    output dw_resp_valid, dw_resp,
    input  dw_resp_ready
  );

endinterface

// File: rtl/copperv_lsu_align.sv
// Byte-lane steering: store strobe/data shift and
// load shift with sign or zero extension.
module copperv_lsu_align #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] st_off,
  input  logic [1:0]                      st_size,
  input  logic [DATA_WIDTH-1:0]           st_data,
  output logic [DATA_WIDTH/8-1:0]         st_strobe,
  output logic [DATA_WIDTH-1:0]           st_wdata,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] ld_off,
  input  logic [2:0]                      ld_funct,
  input  logic [DATA_WIDTH-1:0]           ld_data,
  output logic [DATA_WIDTH-1:0]           ld_rdata
);

  localparam int NB = DATA_WIDTH / 8;

  int                    st_nb;
  int                    ld_bits;
  logic                  sgn;
  logic [DATA_WIDTH-1:0] sh;

  always_comb begin
    st_nb     = 1 << st_size;
    st_strobe = '0;
    for (int i = 0; i < NB; i++) begin
      st_strobe[i] = (i >= int'(st_off)) &&
                     (i < int'(st_off) + st_nb);
    end
    st_wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    sh      = ld_data >> {ld_off, 3'b000};
    ld_bits = 8 << ld_funct[1:0];
    unique case (ld_funct[1:0])
      2'd0:    sgn = sh[7];
      2'd1:    sgn = sh[15];
      2'd2:    sgn = sh[31];
      default: sgn = sh[DATA_WIDTH-1];
    endcase
    ld_rdata = sh;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i >= ld_bits) ld_rdata[i] = ld_funct[2] ? 1'b0 : sgn;
    end
  end

endmodule

// File: rtl/copperv_lsu.sv
// copperv load/store unit: one transaction in flight,
// alignment checks, bus-fail reporting and response timeout.
module copperv_lsu
  import copperv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RESP_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic          clk,
  input logic          rst,
  copperv_lsu_if.master bus
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   =
    TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RESP_WIDTH-1:0] RESP_OK =
    RESP_WIDTH'(DATA_WRITE_RESP_OK);

  lsu_state_t state, state_d;

  logic [OFFW-1:0]       off_q, off_d;
  logic [2:0]            funct_q, funct_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic                  w_valid_q, w_valid_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [NB-1:0]         w_strb_q, w_strb_d;
  logic                  r_valid_q, r_valid_d;
  logic                  r_err_q, r_err_d;
  logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;

  logic [OFFW-1:0]       req_off;
  logic [OFFW-1:0]       szm1;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  illegal;
  logic                  misal;
  logic                  expired;
  logic [NB-1:0]         st_strb;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [DATA_WIDTH-1:0] ld_rdata;

  assign req_off  = bus.req_addr[OFFW-1:0];
  assign req_base = {bus.req_addr[ADDR_WIDTH-1:OFFW],
                     {OFFW{1'b0}}};
  assign illegal  = bus.req_funct[1:0] > 2'(OFFW);
  assign szm1     =
    OFFW'((4'd1 << bus.req_funct[1:0]) - 4'd1);
  assign misal    = |(req_off & szm1);
  assign expired  = TO_EN && (cnt_q == TO_LAST);

  copperv_lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .st_off   (req_off),
    .st_size  (bus.req_funct[1:0]),
    .st_data  (bus.req_wdata),
    .st_strobe(st_strb),
    .st_wdata (st_wdata),
    .ld_off   (off_q),
    .ld_funct (funct_q),
    .ld_data  (bus.dr_data),
    .ld_rdata (ld_rdata)
  );

  always_comb begin
    state_d    = state;
    off_d      = off_q;
    funct_d    = funct_q;
    cnt_d      = cnt_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    w_valid_d  = w_valid_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    r_valid_d  = 1'b0;
    r_err_d    = r_err_q;
    r_rdata_d  = r_rdata_q;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (illegal || misal) begin
            r_valid_d = 1'b1;
            r_err_d   = 1'b1;
            r_rdata_d = '0;
          end else if (bus.req_we) begin
            w_valid_d = 1'b1;
            w_addr_d  = req_base;
            w_data_d  = st_wdata;
            w_strb_d  = st_strb;
            state_d   = WR_REQ;
          end else begin
            ar_valid_d = 1'b1;
            ar_addr_d  = req_base;
            off_d      = req_off;
            funct_d    = bus.req_funct;
            state_d    = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (bus.dr_addr_ready) begin
          ar_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = RD_DATA;
        end
      end
      RD_DATA: begin
        // a beat on the expiry cycle still completes normally
        if (bus.dr_data_valid) begin
          r_valid_d = 1'b1;
          r_err_d   = 1'b0;
          r_rdata_d = ld_rdata;
          state_d   = IDLE;
        end else if (expired) begin
          r_valid_d = 1'b1;
          r_err_d   = 1'b1;
          r_rdata_d = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_REQ: begin
        if (bus.dw_data_addr_ready) begin
          w_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.dw_resp_valid) begin
          r_valid_d = 1'b1;
          r_err_d   = bus.dw_resp != RESP_OK;
          r_rdata_d = '0;
          state_d   = IDLE;
        end else if (expired) begin
          r_valid_d = 1'b1;
          r_err_d   = 1'b1;
          r_rdata_d = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      off_q      <= '0;
      funct_q    <= '0;
      cnt_q      <= '0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      w_valid_q  <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      r_valid_q  <= 1'b0;
      r_err_q    <= 1'b0;
      r_rdata_q  <= '0;
    end else begin
      state      <= state_d;
      off_q      <= off_d;
      funct_q    <= funct_d;
      cnt_q      <= cnt_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      w_valid_q  <= w_valid_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      r_valid_q  <= r_valid_d;
      r_err_q    <= r_err_d;
      r_rdata_q  <= r_rdata_d;
    end
  end

  assign bus.req_ready          = state == IDLE;
  assign bus.resp_valid         = r_valid_q;
  assign bus.resp_err           = r_err_q;
  assign bus.resp_rdata         = r_rdata_q;
  assign bus.dr_addr_valid      = ar_valid_q;
  assign bus.dr_addr            = ar_addr_q;
  assign bus.dr_data_ready      = 1'b1;
  assign bus.dw_data_addr_valid = w_valid_q;
  assign bus.dw_addr            = w_addr_q;
  assign bus.dw_data            = w_data_q;
  assign bus.dw_strobe          = w_strb_q;
  assign bus.dw_resp_ready      = 1'b1;

endmodule

// File: tb/tb_copperv_lsu.sv
// Scoreboard bench for copperv_lsu: 32-bit unit with timeout
// and 64-bit unit, directed vectors with hand-computed results.
module tb_copperv_lsu;
  import copperv_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  copperv_lsu_if #(.DATA_WIDTH(32)) b32();
  copperv_lsu_if #(.DATA_WIDTH(64)) b64();

  copperv_lsu #(
    .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut32 (.clk(clk), .rst(rst), .bus(b32.master));

  copperv_lsu #(
    .DATA_WIDTH(64)
  ) dut64 (.clk(clk), .rst(rst), .bus(b64.master));

  typedef struct {
    string       name;
    bit          err;
    logic [63:0] rdata;
    int          lat;
    time         t0;
    bit          nobus;
    int          snap;
  } exp_t;

  typedef struct {
    string       name;
    bit          we;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } bus_t;

  exp_t rq[$];
  bus_t bq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   busy = 0;

  bit          rd_respond = 1'b1;
  bit          inject32   = 1'b0;
  logic [63:0] rd_word    = '0;
  int          aw_stall   = 0;
  logic [1:0]  wr_resp    = 2'(DATA_WRITE_RESP_OK);

  task automatic chk(string n, logic [63:0] act,
                     logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic bus_chk(bit we, logic [63:0] a,
                         logic [63:0] d, logic [7:0] s,
                         bit pop);
    bus_t e;
    if (bq.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL unexpected bus request: got addr %h expected none", a);
      return;
    end
    e = bq[0];
    if (pop) void'(bq.pop_front());
    chk({e.name, " we"}, 64'(we), 64'(e.we));
    chk({e.name, " addr"}, a, e.addr);
    if (we) begin
      chk({e.name, " data"}, d, e.data);
      chk({e.name, " strobe"}, 64'(s), 64'(e.strb));
    end
  endtask

  task automatic resp_chk(logic err, logic [63:0] rd);
    exp_t e;
    if (rq.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL unexpected resp_valid: got err=%b rdata=%h expected none",
               err, rd);
      return;
    end
    e = rq.pop_front();
    chk({e.name, " err"}, 64'(err), 64'(e.err));
    chk({e.name, " rdata"}, rd, e.rdata);
    chk({e.name, " latency"},
        64'(($time - e.t0) / 10), 64'(e.lat));
    if (e.nobus) chk({e.name, " no bus"}, 64'(busy), 64'(e.snap));
  endtask

  task automatic expect_bus(string n, bit we, logic [63:0] a,
                            logic [63:0] d, logic [7:0] s);
    bus_t e;
    e.name = n;
    e.we   = we;
    e.addr = a;
    e.data = d;
    e.strb = s;
    bq.push_back(e);
  endtask

  task automatic issue(bit d64, string n, bit we,
                       logic [2:0] f, logic [63:0] a,
                       logic [63:0] wd, bit push, bit err,
                       logic [63:0] rd, int lat);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    while (!(d64 ? b64.req_ready : b32.req_ready)) begin
      if (++w > 50) begin
        nvec++;
        nerr++;
        $display("FAIL %s: req_ready got 0 expected 1 within 50 cycles", n);
        return;
      end
      @(negedge clk);
    end
    if (d64) begin
      b64.req_valid = 1'b1;
      b64.req_we    = we;
      b64.req_funct = f;
      b64.req_addr  = a[31:0];
      b64.req_wdata = wd;
    end else begin
      b32.req_valid = 1'b1;
      b32.req_we    = we;
      b32.req_funct = f;
      b32.req_addr  = a[31:0];
      b32.req_wdata = wd[31:0];
    end
    e.name  = n;
    e.err   = err;
    e.rdata = rd;
    e.lat   = lat;
    e.t0    = $time;
    e.nobus = err && lat == 1;
    e.snap  = busy;
    if (push) rq.push_back(e);
    @(posedge clk);
    #1;
    b32.req_valid = 1'b0;
    b64.req_valid = 1'b0;
  endtask

  task automatic drain(string n);
    int w = 0;
    while (rq.size() != 0 || bq.size() != 0) begin
      @(negedge clk);
      if (++w > 100) begin
        nvec++;
        nerr++;
        $display("FAIL %s: got %0d responses outstanding expected 0",
                 n, rq.size());
        rq.delete();
        bq.delete();
        return;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // 32-bit memory model
  always @(posedge clk) begin
    bit ar, aw, stl;
    ar  = b32.dr_addr_valid && b32.dr_addr_ready;
    aw  = b32.dw_data_addr_valid && b32.dw_data_addr_ready;
    stl = b32.dw_data_addr_valid && !b32.dw_data_addr_ready;
    if (!rst && ar) bus_chk(1'b0, 64'(b32.dr_addr), '0, '0, 1'b1);
    if (!rst && (aw || stl))
      bus_chk(1'b1, 64'(b32.dw_addr), 64'(b32.dw_data),
              8'(b32.dw_strobe), aw);
    #1;
    b32.dr_data_valid = 1'b0;
    b32.dw_resp_valid = 1'b0;
    if (inject32) begin
      b32.dr_data_valid = 1'b1;
      b32.dr_data       = 32'h5A5A_5A5A;
      inject32          = 1'b0;
    end
    if (ar && rd_respond) begin
      b32.dr_data_valid = 1'b1;
      b32.dr_data       = rd_word[31:0];
    end
    if (aw) begin
      b32.dw_resp_valid = 1'b1;
      b32.dw_resp       = wr_resp;
    end
    if (stl && aw_stall > 0) aw_stall--;
    b32.dw_data_addr_ready = aw_stall == 0;
  end

  // 64-bit memory model, zero-wait, always OK
  always @(posedge clk) begin
    bit ar, aw;
    ar = b64.dr_addr_valid && b64.dr_addr_ready;
    aw = b64.dw_data_addr_valid && b64.dw_data_addr_ready;
    if (!rst && ar) bus_chk(1'b0, 64'(b64.dr_addr), '0, '0, 1'b1);
    if (!rst && aw)
      bus_chk(1'b1, 64'(b64.dw_addr), b64.dw_data,
              b64.dw_strobe, 1'b1);
    #1;
    b64.dr_data_valid = ar;
    b64.dr_data       = rd_word;
    b64.dw_resp_valid = aw;
    b64.dw_resp       = 2'(DATA_WRITE_RESP_OK);
  end

  always @(negedge clk) begin
    if (b32.dr_addr_valid || b32.dw_data_addr_valid ||
        b64.dr_addr_valid || b64.dw_data_addr_valid)
      busy++;
    if (!rst && b32.resp_valid)
      resp_chk(b32.resp_err, {32'h0, b32.resp_rdata});
    if (!rst && b64.resp_valid)
      resp_chk(b64.resp_err, b64.resp_rdata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b32.req_valid = 1'b0;
    b32.req_we    = 1'b0;
    b32.req_funct = '0;
    b32.req_addr  = '0;
    b32.req_wdata = '0;
    b32.dr_addr_ready      = 1'b1;
    b32.dr_data_valid      = 1'b0;
    b32.dr_data            = '0;
    b32.dw_data_addr_ready = 1'b1;
    b32.dw_resp_valid      = 1'b0;
    b32.dw_resp            = '0;
    b64.req_valid = 1'b0;
    b64.req_we    = 1'b0;
    b64.req_funct = '0;
    b64.req_addr  = '0;
    b64.req_wdata = '0;
    b64.dr_addr_ready      = 1'b1;
    b64.dr_data_valid      = 1'b0;
    b64.dr_data            = '0;
    b64.dw_data_addr_ready = 1'b1;
    b64.dw_resp_valid      = 1'b0;
    b64.dw_resp            = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", 64'(b32.req_ready), 64'd1);
    chk("rst resp_valid", 64'(b32.resp_valid), 64'd0);
    chk("rst resp_err", 64'(b32.resp_err), 64'd0);
    chk("rst resp_rdata", 64'(b32.resp_rdata), 64'd0);
    chk("rst dr_addr_valid", 64'(b32.dr_addr_valid), 64'd0);
    chk("rst dw_valid", 64'(b32.dw_data_addr_valid), 64'd0);
    chk("rst dr_addr", 64'(b32.dr_addr), 64'd0);
    chk("rst dw_strobe", 64'(b32.dw_strobe), 64'd0);
    chk("rst dw_data", 64'(b32.dw_data), 64'd0);
    chk("rst dr_data_ready", 64'(b32.dr_data_ready), 64'd1);
    chk("rst dw_resp_ready", 64'(b32.dw_resp_ready), 64'd1);
    chk("rst dw_strobe64", 64'(b64.dw_strobe), 64'd0);

    rd_word = 64'hDEAD_BEEF;
    expect_bus("lw", 1'b0, 64'h104, '0, '0);
    issue(0, "lw", 0, 3'b010, 64'h104, '0, 1, 0,
          64'hDEAD_BEEF, 3);
    drain("lw");

    rd_word = 64'h80FF_0000;
    expect_bus("lb", 1'b0, 64'h100, '0, '0);
    issue(0, "lb", 0, 3'b000, 64'h103, '0, 1, 0,
          64'hFFFF_FF80, 3);
    expect_bus("lbu", 1'b0, 64'h100, '0, '0);
    issue(0, "lbu", 0, 3'b100, 64'h103, '0, 1, 0,
          64'h0000_0080, 3);
    expect_bus("lh", 1'b0, 64'h100, '0, '0);
    issue(0, "lh", 0, 3'b001, 64'h102, '0, 1, 0,
          64'hFFFF_80FF, 3);
    expect_bus("lhu", 1'b0, 64'h100, '0, '0);
    issue(0, "lhu", 0, 3'b101, 64'h102, '0, 1, 0,
          64'h0000_80FF, 3);
    drain("lb");

    expect_bus("sh", 1'b1, 64'h100, 64'h1234_0000, 8'b1100);
    issue(0, "sh", 1, 3'b001, 64'h102, 64'h1234, 1, 0, '0, 3);
    expect_bus("sb", 1'b1, 64'h100, 64'h0000_AB00, 8'b0010);
    issue(0, "sb", 1, 3'b000, 64'h101, 64'hAB, 1, 0, '0, 3);
    drain("sh");

    issue(0, "lw misal", 0, 3'b010, 64'h102, '0, 1, 1, '0, 1);
    issue(0, "sh misal", 1, 3'b001, 64'h101, 64'h55, 1, 1,
          '0, 1);
    issue(0, "ld32 illegal", 0, 3'b011, 64'h100, '0, 1, 1,
          '0, 1);
    drain("misal");

    aw_stall = 5;
    wr_resp  = 2'(DATA_WRITE_RESP_FAIL);
    @(negedge clk);
    expect_bus("sw stall", 1'b1, 64'h200, 64'hCAFE_F00D,
               8'b1111);
    issue(0, "sw stall", 1, 3'b010, 64'h200, 64'hCAFE_F00D,
          1, 1, '0, 8);
    drain("sw stall");
    wr_resp = 2'(DATA_WRITE_RESP_OK);

    rd_respond = 1'b0;
    expect_bus("lw timeout", 1'b0, 64'h300, '0, '0);
    issue(0, "lw timeout", 0, 3'b010, 64'h300, '0, 1, 1,
          '0, 6);
    drain("timeout");
    inject32 = 1'b1;
    repeat (3) @(negedge clk);
    chk("late beat resp_valid", 64'(b32.resp_valid), 64'd0);
    chk("late beat req_ready", 64'(b32.req_ready), 64'd1);

    expect_bus("lw rst", 1'b0, 64'h400, '0, '0);
    issue(0, "lw rst", 0, 3'b010, 64'h400, '0, 0, 0, '0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid rd_data req_ready", 64'(b32.req_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort req_ready", 64'(b32.req_ready), 64'd1);
    chk("abort dr_addr_valid", 64'(b32.dr_addr_valid), 64'd0);
    repeat (6) @(negedge clk);
    chk("abort resp_valid", 64'(b32.resp_valid), 64'd0);
    rd_respond = 1'b1;
    drain("abort");

    rd_word = 64'h0123_4567_89AB_CDEF;
    expect_bus("ld64", 1'b0, 64'h8, '0, '0);
    issue(1, "ld64", 0, 3'b011, 64'h8, '0, 1, 0,
          64'h0123_4567_89AB_CDEF, 3);
    expect_bus("sw64", 1'b1, 64'h8, 64'hA5A5_A5A5_0000_0000,
               8'hF0);
    issue(1, "sw64", 1, 3'b010, 64'hC, 64'hA5A5_A5A5, 1, 0,
          '0, 3);
    issue(1, "ld64 misal", 0, 3'b011, 64'hC, '0, 1, 1, '0, 1);
    drain("d64a");

    rd_word = 64'h8000_0000_1234_5678;
    expect_bus("lw64", 1'b0, 64'h8, '0, '0);
    issue(1, "lw64", 0, 3'b010, 64'hC, '0, 1, 0,
          64'hFFFF_FFFF_8000_0000, 3);
    expect_bus("lwu64", 1'b0, 64'h8, '0, '0);
    issue(1, "lwu64", 0, 3'b110, 64'hC, '0, 1, 0,
          64'h0000_0000_8000_0000, 3);
    drain("d64b");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
